wb_stage: RTL and testbench



---
 rtl/wb_stage_pkg.sv | 58 +++++
 rtl/wb_cp0_regs.sv | 179 +++++++++++++++++
 rtl/wb_stage.sv | 115 +++++++++++
 tb/tb_wb_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// ============================================================================
// Module      : wb_stage_pkg
// Description : Shared constants, bus layout and helpers for the write-back
//               stage and its CP0 register file.
// Options     : CP0_TIMER_EN (consumed by wb_cp0_regs)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_stage_pkg;

    // Bus widths
    localparam int unsigned c_ms_to_ws_bus_wd   = 124;
    localparam int unsigned c_ws_fwd_blk_bus_wd = 42;

    // Exception vector
    localparam logic [31:0] c_ex_entry = 32'hbfc00380;

    // CP0 register addresses, {rd, sel}
    localparam logic [7:0] c_cp0_badvaddr = 8'h40;
    localparam logic [7:0] c_cp0_count    = 8'h48;
    localparam logic [7:0] c_cp0_compare  = 8'h58;
    localparam logic [7:0] c_cp0_status   = 8'h60;
    localparam logic [7:0] c_cp0_cause    = 8'h68;
    localparam logic [7:0] c_cp0_epc      = 8'h70;

    // Exception codes
    localparam logic [4:0] c_exc_int  = 5'd0;
    localparam logic [4:0] c_exc_adel = 5'd4;
    localparam logic [4:0] c_exc_ades = 5'd5;
    localparam logic [4:0] c_exc_sys  = 5'd8;
    localparam logic [4:0] c_exc_ov   = 5'd12;

    // Memory-stage to write-back bus, MSB first
    typedef struct packed {
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [7:0]  cp0_addr;
        logic        ex;
        logic        bd;
        logic        eret;
        logic        syscall;
        logic        mfc0;
        logic        mtc0;
        logic [3:0]  gr_strb;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_to_ws_t;

    // Address-error exceptions are the only ones that capture BadVAddr
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == c_exc_adel) || (code == c_exc_ades);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_cp0_regs.sv
// ============================================================================
// Module      : wb_cp0_regs
// Description : CP0 state (Status, Cause, EPC, BadVAddr, Count, Compare),
//               the mfc0 read mux and the pending-interrupt flag.
// Options     : CP0_TIMER_EN - enables the Count/Compare timer and TI
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cp0_regs
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [5:0]  i_ext_int,
    input  logic        i_ex_commit,
    input  logic        i_eret_commit,
    input  logic [4:0]  i_excode,
    input  logic        i_bd,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_badvaddr,
    input  logic        i_mtc0_we,
    input  logic [7:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_epc,
    output logic        o_has_int
);

    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exccode;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;

    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;

    assign w_wr_status = i_mtc0_we && (i_addr == c_cp0_status);
    assign w_wr_cause  = i_mtc0_we && (i_addr == c_cp0_cause);
    assign w_wr_epc    = i_mtc0_we && (i_addr == c_cp0_epc);

    // Status: software owns IM/IE, exception entry and ERET own EXL
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_status_im  <= 8'd0;
            r_status_exl <= 1'b0;
            r_status_ie  <= 1'b0;
        end else begin
            if (w_wr_status) begin
                r_status_im <= i_wdata[15:8];
                r_status_ie <= i_wdata[0];
            end
            if (i_ex_commit) begin
                r_status_exl <= 1'b1;
            end else if (i_eret_commit) begin
                r_status_exl <= 1'b0;
            end
        end
    end

    // Cause: hardware IP sampled every cycle, BD only recorded on first entry
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cause_bd      <= 1'b0;
            r_cause_ip_hw   <= 6'd0;
            r_cause_ip_sw   <= 2'd0;
            r_cause_exccode <= 5'd0;
        end else begin
            r_cause_ip_hw <= {i_ext_int[5] | w_ti, i_ext_int[4:0]};
            if (w_wr_cause) begin
                r_cause_ip_sw <= i_wdata[9:8];
            end
            if (i_ex_commit) begin
                r_cause_exccode <= i_excode;
                if (!r_status_exl) begin
                    r_cause_bd <= i_bd;
                end
            end
        end
    end

    // EPC: a nested exception (EXL already set) keeps the original return PC
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_epc <= 32'd0;
        end else if (i_ex_commit) begin
            if (!r_status_exl) begin
                r_epc <= i_bd ? (i_pc - 32'd4) : i_pc;
            end
        end else if (w_wr_epc) begin
            r_epc <= i_wdata;
        end
    end

    // BadVAddr: captured only on address-error exceptions
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_badvaddr <= 32'd0;
        end else if (i_ex_commit && is_addr_exc(i_excode)) begin
            r_badvaddr <= i_badvaddr;
        end
    end

`ifdef CP0_TIMER_EN
    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_wr_count   = i_mtc0_we && (i_addr == c_cp0_count);
    assign w_wr_compare = i_mtc0_we && (i_addr == c_cp0_compare);

    // Half-rate timer: software writes win over the tick and the match
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_tick    <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (w_wr_count) begin
                r_count <= i_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
            if (w_wr_compare) begin
                r_compare <= i_wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_ti      = r_ti;
    assign w_count   = r_count;
    assign w_compare = r_compare;
`else
    assign w_ti      = 1'b0;
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
`endif

    // mfc0 read mux; unmapped addresses read as zero
    always_comb begin
        o_rdata = 32'd0;
        case (i_addr)
            c_cp0_badvaddr: o_rdata = r_badvaddr;
            c_cp0_count:    o_rdata = w_count;
            c_cp0_compare:  o_rdata = w_compare;
            c_cp0_status:   o_rdata = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0,
                                       r_status_exl, r_status_ie};
            c_cp0_cause:    o_rdata = {r_cause_bd, w_ti, 14'd0, r_cause_ip_hw,
                                       r_cause_ip_sw, 1'b0, r_cause_exccode, 2'd0};
            c_cp0_epc:      o_rdata = r_epc;
            default:        o_rdata = 32'd0;
        endcase
    end

    assign o_epc     = r_epc;
    assign o_has_int = (|({r_cause_ip_hw, r_cause_ip_sw} & r_status_im))
                       && r_status_ie && !r_status_exl;

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : Write-back pipeline stage: commits byte-strobed register
//               writes, hosts CP0, raises exception/ERET flushes and
//               publishes forwarding and debug-trace buses.
// Options     : CP0_TIMER_EN - enables the CP0 Count/Compare timer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned MS_TO_WS_BUS_WD = c_ms_to_ws_bus_wd,
    parameter logic [31:0] EX_ENTRY        = c_ex_entry
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ws_allowin,
    input  logic [5:0]                 ext_int_in,
    output logic [3:0]                 rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [41:0]                ws_fwd_blk_bus,
    output logic                       ws_ex,
    output logic                       eret_flush,
    output logic [31:0]                ex_target,
    output logic                       has_int,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    logic        r_ws_valid;
    ms_to_ws_t   r_bus;

    logic        w_ready_go;
    logic        w_ws_ex;
    logic        w_eret_flush;
    logic        w_mtc0_we;
    logic [3:0]  w_rf_we;
    logic [31:0] w_rf_wdata;
    logic [31:0] w_cp0_rdata;
    logic [31:0] w_cp0_epc;
    logic        w_unused_syscall;

    assign w_ready_go       = 1'b1;
    assign ws_allowin       = resetn && (!r_ws_valid || w_ready_go);
    assign w_unused_syscall = r_bus.syscall;

    // Stage valid: a committed flush drops whatever arrives behind it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ws_valid <= 1'b0;
        end else if (w_ws_ex || w_eret_flush) begin
            r_ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            r_ws_valid <= ms_to_ws_valid;
        end
    end

    // Capture the memory-stage bus on an accepted handshake
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_bus <= '0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            r_bus <= ms_to_ws_bus;
        end
    end

    assign w_ws_ex      = r_ws_valid && r_bus.ex;
    assign w_eret_flush = r_ws_valid && r_bus.eret && !r_bus.ex;
    assign w_mtc0_we    = r_ws_valid && r_bus.mtc0 && !r_bus.ex;
    assign w_rf_we      = {4{r_ws_valid && !r_bus.ex}} & r_bus.gr_strb;
    assign w_rf_wdata   = r_bus.mfc0 ? w_cp0_rdata : r_bus.result;

    wb_cp0_regs u_cp0 (
        .clk           (clk),
        .i_rst_n       (resetn),
        .i_ext_int     (ext_int_in),
        .i_ex_commit   (w_ws_ex),
        .i_eret_commit (w_eret_flush),
        .i_excode      (r_bus.excode),
        .i_bd          (r_bus.bd),
        .i_pc          (r_bus.pc),
        .i_badvaddr    (r_bus.badvaddr),
        .i_mtc0_we     (w_mtc0_we),
        .i_addr        (r_bus.cp0_addr),
        .i_wdata       (r_bus.result),
        .o_rdata       (w_cp0_rdata),
        .o_epc         (w_cp0_epc),
        .o_has_int     (has_int)
    );

    assign rf_we      = w_rf_we;
    assign rf_waddr   = r_bus.dest;
    assign rf_wdata   = w_rf_wdata;
    assign ws_ex      = w_ws_ex;
    assign eret_flush = w_eret_flush;
    assign ex_target  = w_ws_ex      ? EX_ENTRY  :
                        w_eret_flush ? w_cp0_epc : 32'd0;

    assign ws_fwd_blk_bus = {r_ws_valid && r_bus.mfc0, w_rf_we, r_bus.dest, w_rf_wdata};

    assign debug_wb_pc       = r_bus.pc;
    assign debug_wb_rf_wen   = w_rf_we;
    assign debug_wb_rf_wnum  = r_bus.dest;
    assign debug_wb_rf_wdata = w_rf_wdata;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage with a behavioural CP0
//               model; directed scenarios followed by random instructions.
// Options     : CP0_TIMER_EN - selects the timer scenario
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

    localparam logic [31:0] c_exv = 32'hbfc00380;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ms_to_ws_valid;
    logic [123:0] ms_to_ws_bus;
    logic         ws_allowin;
    logic [5:0]   ext_int_in;
    logic [3:0]   rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [41:0]  ws_fwd_blk_bus;
    logic         ws_ex;
    logic         eret_flush;
    logic [31:0]  ex_target;
    logic         has_int;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_wen;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    // Reference CP0 state
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_exccode;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    logic [31:0] m_epc, m_badv;

    logic [7:0] wr_addrs [6] = '{8'h60, 8'h68, 8'h70, 8'h08, 8'h48, 8'h58};
    logic [7:0] rd_addrs [8] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00, 8'h78};
    logic [4:0] exc_codes [5] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd12};

    wb_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allowin        (ws_allowin),
        .ext_int_in        (ext_int_in),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_fwd_blk_bus    (ws_fwd_blk_bus),
        .ws_ex             (ws_ex),
        .eret_flush        (eret_flush),
        .ex_target         (ex_target),
        .has_int           (has_int),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [123:0] mk(input logic [4:0] excode, input logic [31:0] badv,
                                        input logic [7:0] addr, input logic ex, input logic bd,
                                        input logic eret, input logic mfc0, input logic mtc0,
                                        input logic [3:0] strb, input logic [4:0] dest,
                                        input logic [31:0] res, input logic [31:0] pc);
        return {excode, badv, addr, ex, bd, eret, 1'b0, mfc0, mtc0, strb, dest, res, pc};
    endfunction

    function automatic logic [123:0] mk_alu(input logic [3:0] s, input logic [4:0] d,
                                            input logic [31:0] r, input logic [31:0] pc);
        return mk(5'd0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s, d, r, pc);
    endfunction

    function automatic logic [123:0] mk_mtc0(input logic [7:0] a, input logic [31:0] d,
                                             input logic [31:0] pc);
        return mk(5'd0, 32'd0, a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0, d, pc);
    endfunction

    function automatic logic [123:0] mk_mfc0(input logic [7:0] a, input logic [4:0] d,
                                             input logic [31:0] pc);
        return mk(5'd0, 32'd0, a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hf, d, 32'hcafef00d, pc);
    endfunction

    function automatic logic [123:0] mk_exc(input logic [4:0] code, input logic [31:0] badv,
                                            input logic bd, input logic [31:0] pc,
                                            input logic eret);
        return mk(code, badv, 8'd0, 1'b1, bd, eret, 1'b0, 1'b0, 4'hf, 5'd9, 32'h12345678, pc);
    endfunction

    function automatic logic [123:0] mk_eret(input logic [31:0] pc);
        return mk(5'd0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 32'd0, pc);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h40:   return m_badv;
            8'h60:   return {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
            8'h68:   return {m_bd, 1'b0, 14'd0, m_iphw, m_ipsw, 1'b0, m_exccode, 2'd0};
            8'h70:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_has_int();
        return (|({m_iphw, m_ipsw} & m_im)) && m_ie && !m_exl;
    endfunction

    task automatic model_reset();
        m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_exccode = 5'd0;
        m_ipsw = 2'd0; m_iphw = 6'd0; m_epc = 32'd0; m_badv = 32'd0;
    endtask

    // Present one instruction, check its write-back cycle, then apply its
    // architectural effect to the model
    task automatic send(input logic [123:0] b);
        logic [4:0]  f_excode;
        logic [31:0] f_badv, f_res, f_pc, e_wdata, e_tgt, mask;
        logic [7:0]  f_addr;
        logic        f_ex, f_bd, f_eret, f_mfc0, f_mtc0, e_eret;
        logic [3:0]  f_strb, e_we;
        logic [4:0]  f_dest;
        f_excode = b[123:119]; f_badv = b[118:87]; f_addr = b[86:79];
        f_ex = b[78]; f_bd = b[77]; f_eret = b[76]; f_mfc0 = b[74]; f_mtc0 = b[73];
        f_strb = b[72:69]; f_dest = b[68:64]; f_res = b[63:32]; f_pc = b[31:0];
        e_eret  = f_eret && !f_ex;
        e_we    = f_ex ? 4'd0 : f_strb;
        e_wdata = f_mfc0 ? m_read(f_addr) : f_res;
        e_tgt   = f_ex ? c_exv : m_epc;
        mask    = 32'hffffffff;
`ifdef CP0_TIMER_EN
        if (f_mfc0 && f_addr == 8'h68) mask = 32'hbfff7fff;
`endif
        ms_to_ws_bus = b;
        ms_to_ws_valid = 1'b1;
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        chk("ws_ex", ws_ex, f_ex);
        chk("eret_flush", eret_flush, e_eret);
        if (f_ex || e_eret) chk("ex_target", ex_target, e_tgt);
        chk("rf_we", rf_we, e_we);
        chk("rf_waddr", rf_waddr, f_dest);
        chk("rf_wdata", rf_wdata & mask, e_wdata & mask);
        chk("fwd_bus", ws_fwd_blk_bus & {10'h3ff, mask}, {f_mfc0, e_we, f_dest, e_wdata & mask});
        chk("dbg_pc", debug_wb_pc, f_pc);
        chk("dbg_wen", debug_wb_rf_wen, e_we);
        chk("dbg_wnum", debug_wb_rf_wnum, f_dest);
        chk("ws_allowin", ws_allowin, 1'b1);
`ifdef CP0_TIMER_EN
        if (!m_im[7]) chk("has_int", has_int, m_has_int());
`else
        chk("has_int", has_int, m_has_int());
`endif
        if (f_ex) begin
            m_exccode = f_excode;
            if (!m_exl) begin
                m_epc = f_bd ? f_pc - 32'd4 : f_pc;
                m_bd  = f_bd;
            end
            m_exl = 1'b1;
            if (f_excode == 5'd4 || f_excode == 5'd5) m_badv = f_badv;
        end else if (e_eret) begin
            m_exl = 1'b0;
        end else if (f_mtc0) begin
            if (f_addr == 8'h60) begin m_im = f_res[15:8]; m_ie = f_res[0]; end
            if (f_addr == 8'h68) m_ipsw = f_res[9:8];
            if (f_addr == 8'h70) m_epc = f_res;
        end
        // The instruction right behind a flush must be discarded
        if (f_ex || e_eret) begin
            ms_to_ws_bus = mk_alu(4'hf, 5'd31, 32'hdeadbeef, f_pc + 32'd4);
            ms_to_ws_valid = 1'b1;
            @(posedge clk); #1;
            ms_to_ws_valid = 1'b0;
            chk("flush_drop_we", rf_we, 4'd0);
            chk("flush_drop_ex", ws_ex, 1'b0);
        end
    endtask

    initial begin
        logic seen;
        resetn = 1'b0; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; ext_int_in = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_allowin", ws_allowin, 1'b0);
        chk("rst_rf_we", rf_we, 4'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_fwd", ws_fwd_blk_bus, 42'd0);
        chk("rst_flush", {ws_ex, eret_flush, has_int}, 3'd0);
        chk("rst_target", ex_target, 32'd0);
        chk("rst_dbg_pc", debug_wb_pc, 32'd0);
        resetn = 1'b1;
        model_reset();

        // Byte-strobed load
        send(mk_alu(4'b0110, 5'd5, 32'h11223344, 32'hbfc00000));
        chk("load_we_const", rf_we, 4'b0110);
        send(mk_mfc0(8'h60, 5'd2, 32'hbfc00004));
        chk("status_reset_const", rf_wdata, 32'h00400000);

        // Syscall
        send(mk_exc(5'd8, 32'd0, 1'b0, 32'hbfc00100, 1'b0));
        send(mk_mfc0(8'h70, 5'd3, 32'hbfc00380));
        chk("sys_epc_const", rf_wdata, 32'hbfc00100);
        send(mk_mfc0(8'h68, 5'd3, 32'hbfc00384));
        send(mk_mfc0(8'h60, 5'd3, 32'hbfc00388));

        // ERET to a software-written EPC
        send(mk_mtc0(8'h70, 32'hbfc00300, 32'hbfc0038c));
        send(mk_eret(32'hbfc00390));
        send(mk_mfc0(8'h60, 5'd4, 32'hbfc00300));

        // Delay-slot exception, then a nested one with EXL set
        send(mk_exc(5'd4, 32'h00000123, 1'b1, 32'hbfc00204, 1'b0));
        send(mk_mfc0(8'h70, 5'd6, 32'hbfc00380));
        chk("bd_epc_const", rf_wdata, 32'hbfc00200);
        send(mk_exc(5'd12, 32'h0badbad0, 1'b0, 32'hbfc00380, 1'b0));
        send(mk_mfc0(8'h70, 5'd6, 32'hbfc00380));
        chk("nested_epc_const", rf_wdata, 32'hbfc00200);
        send(mk_mfc0(8'h68, 5'd6, 32'hbfc00384));
        send(mk_mfc0(8'h40, 5'd6, 32'hbfc00388));

        // ERET together with an exception: only the exception flushes
        send(mk_exc(5'd0, 32'd0, 1'b0, 32'hbfc00390, 1'b1));
        send(mk_eret(32'hbfc00394));

        // Random instruction mix
        for (int i = 0; i < 80; i++) begin
            int kind;
            logic [31:0] rpc, rd;
            logic [7:0] a;
            kind = $urandom_range(0, 9);
            rpc  = $urandom & 32'hfffffffc;
            rd   = $urandom;
            case (kind)
                0, 1, 2: send(mk_alu(4'($urandom), 5'($urandom), rd, rpc));
                3, 4: begin
                    a = wr_addrs[$urandom_range(0, 5)];
`ifdef CP0_TIMER_EN
                    rd[15] = 1'b0;
                    if (a == 8'h48 || a == 8'h58) a = 8'h10;
`endif
                    send(mk_mtc0(a, rd, rpc));
                end
                5, 6: begin
                    a = rd_addrs[$urandom_range(0, 7)];
`ifdef CP0_TIMER_EN
                    if (a == 8'h48 || a == 8'h58) a = 8'h78;
`endif
                    send(mk_mfc0(a, 5'($urandom), rpc));
                end
                7: send(mk_exc(exc_codes[$urandom_range(0, 4)], rd, 1'($urandom), rpc,
                               1'($urandom)));
                8: send(mk_eret(rpc));
                default: send(mk_alu(4'd0, 5'($urandom), rd, rpc));
            endcase
        end

        // External interrupts, masked by EXL during an exception
        send(mk_eret(32'hbfc00500));
        send(mk_mtc0(8'h68, 32'd0, 32'hbfc00504));
        send(mk_mtc0(8'h60, 32'h00007f01, 32'hbfc00508));
        ext_int_in = 6'b000101;
        repeat (2) @(posedge clk);
        #1;
        m_iphw = 6'b000101;
        chk("ext_has_int", has_int, 1'b1);
        send(mk_mfc0(8'h68, 5'd7, 32'hbfc0050c));
        send(mk_exc(5'd0, 32'd0, 1'b0, 32'hbfc00510, 1'b0));
        send(mk_mfc0(8'h60, 5'd7, 32'hbfc00380));
        send(mk_eret(32'hbfc00384));
        ext_int_in = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        m_iphw = 6'd0;
        chk("ext_clear_has_int", has_int, m_has_int());

        // Timer
        send(mk_mtc0(8'h48, 32'd0, 32'hbfc00600));
        send(mk_mtc0(8'h58, 32'd10, 32'hbfc00604));
        send(mk_mtc0(8'h60, 32'h00008001, 32'hbfc00608));
        seen = 1'b0;
`ifdef CP0_TIMER_EN
        for (int k = 2; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k <= 16) chk("timer_early", has_int, 1'b0);
            else if (has_int) seen = 1'b1;
        end
        chk("timer_ti_set", seen, 1'b1);
        send(mk_mtc0(8'h58, 32'hffffffff, 32'hbfc0060c));
        repeat (2) @(posedge clk);
        #1;
        chk("timer_ti_clear", has_int, 1'b0);
`else
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            seen = seen | has_int;
        end
        chk("timer_off_no_ti", seen, 1'b0);
        send(mk_mfc0(8'h48, 5'd8, 32'hbfc0060c));
        send(mk_mfc0(8'h58, 5'd8, 32'hbfc00610));
        send(mk_mfc0(8'h68, 5'd8, 32'hbfc00614));
`endif
        send(mk_mtc0(8'h60, 32'd0, 32'hbfc00618));

        // Reset mid-stream with live state
        send(mk_mtc0(8'h68, 32'h00000300, 32'hbfc00700));
        send(mk_mtc0(8'h60, 32'h00000301, 32'hbfc00704));
        send(mk_alu(4'hf, 5'd1, 32'h0, 32'hbfc00708));
        ms_to_ws_bus = mk_alu(4'hf, 5'd7, 32'h55aa55aa, 32'hbfc00400);
        ms_to_ws_valid = 1'b1;
        resetn = 1'b0;
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        chk("mid_rst_we", rf_we, 4'd0);
        chk("mid_rst_allowin", ws_allowin, 1'b0);
        chk("mid_rst_int", has_int, 1'b0);
        chk("mid_rst_pc", debug_wb_pc, 32'd0);
        chk("mid_rst_fwd", ws_fwd_blk_bus, 42'd0);
        chk("mid_rst_flush", {ws_ex, eret_flush}, 2'd0);
        resetn = 1'b1;
        model_reset();
        send(mk_mfc0(8'h60, 5'd1, 32'hbfc00000));
        chk("mid_rst_status_const", rf_wdata, 32'h00400000);
        send(mk_mfc0(8'h70, 5'd1, 32'hbfc00004));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
